axadd_err_monitor: RTL and testbench
====================================

Name: axadd_err_monitor

Overview:
- Sequential error-metric collector at the consumer end of an approximate adder (copy/LOA/truncation/ETA family).
- Accepts operand pairs plus the approximate sum the adder under test produced, and recomputes the exact sum internally.
- Accumulates error statistics over a programmed batch of samples and reports them when the batch completes.
- Sits beside an approximate adder instance in characterisation harnesses and in on-chip self-test wrappers.

Parameters:
- BIT_WIDTH, 8, operand width; sums are BIT_WIDTH+1 bits.
- CNT_WIDTH, 16, width of the batch-size and sample counters.
- ACC_WIDTH, 32, width of the error accumulators (must be >= BIT_WIDTH+2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a batch; honoured only in IDLE or DONE.
- num_samples  in  CNT_WIDTH  batch size, sampled on an accepted start.
- in_valid  in  1  sample present on A/B/APPROX.
- in_ready  out  1  block can accept a sample.
- A  in  BIT_WIDTH  operand A.
- B  in  BIT_WIDTH  operand B.
- APPROX  in  BIT_WIDTH+1  approximate sum under test.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- sample_count  out  CNT_WIDTH  samples accepted in the current batch.
- err_count  out  CNT_WIDTH  samples with a nonzero error.
- sed  out  ACC_WIDTH  sum of |exact - APPROX|, unsigned, saturating.
- bias  out  ACC_WIDTH  signed sum of (APPROX - exact), two's complement, saturating.
- sat  out  1  sticky; set when sed or bias saturates.

Behaviour:
- Reset: state = IDLE. All outputs and accumulators are 0; in_ready=0, busy=0, done=0, sat=0.
- States and transitions:
  - IDLE → RUN on start when num_samples != 0.
  - IDLE → DONE on start when num_samples == 0. DONE is reached on the next edge; stats stay cleared.
  - RUN → DRAIN on the edge that accepts sample number num_samples.
  - DRAIN → DONE once both pipeline stages are empty (2 cycles after the last accept).
  - DONE → RUN or DONE on start, using the same num_samples rule as IDLE.
- An accepted start clears sample_count, err_count, sed, bias and sat. start in RUN or DRAIN is ignored.
- in_ready is 1 only in RUN. A sample is accepted when in_valid && in_ready. Samples offered in other states are not consumed.
- Stage 1, the cycle of acceptance: register exact = A + B (BIT_WIDTH+1 bits, zero-extended) and APPROX. Increment sample_count.
- Stage 2: d = APPROX - exact, computed as a signed BIT_WIDTH+2-bit value; ed = |d|.
  - If ed != 0, err_count increments.
  - sed += ed, clamped at 2^ACC_WIDTH-1.
  - bias += d, clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets sat.
- Latency: a sample's contribution is visible on err_count/sed/bias 2 cycles after its accept edge.
- Throughput: one sample per cycle. Gaps in in_valid are allowed and do not corrupt the pipeline.
- Stats hold stable throughout DONE until the next accepted start.
- err_count cannot overflow, since it is bounded by num_samples.
- rst asserted mid-batch returns the block to IDLE immediately and clears everything. In-flight samples are discarded.

Optional Feature:
- Macro: AXERR_MAXED_EN.
- When defined, adds output max_ed [BIT_WIDTH+1:0]: the largest ed seen in the batch, updated in stage 2 and cleared by reset and by an accepted start.
- When undefined, the port and its register are absent and all other behaviour is unchanged.

Test Plan:
- Exact samples: start with num_samples=4; inputs (A,B,APPROX) = (10,20,30), (255,255,510), (0,0,0), (1,2,3) → done asserts, sample_count=4, err_count=0, sed=0, bias=0, sat=0.
- Truncation-style error: num_samples=1; A=0x1F, B=0x01, APPROX=0x000 (exact 0x20) → 2 cycles after accept, sed=32, bias=-32, err_count=1; then DONE (max_ed=32 when AXERR_MAXED_EN is defined).
- Zero batch: start with num_samples=0 → DONE on the next edge with in_ready never high and all stats 0. A second start with num_samples=2 restarts into RUN with cleared stats.
- Back-pressure: num_samples=3 with in_valid toggling 1,0,1,1,1 → exactly 3 samples accepted, in_ready falls after the third, the fifth beat is not consumed, sample_count=3.
- Reset mid-batch: assert rst after 2 of 5 samples → state IDLE, all outputs 0 immediately. Later samples are ignored until the next start.
- Saturation: ACC_WIDTH=10, BIT_WIDTH=8; 5 samples each with APPROX=0, A=B=255 (ed=510) → sed=1023, bias=-512, sat=1 and held through DONE.

Source files
------------

// File: rtl/axadd_err_monitor.sv
// rtl/axadd_err_monitor.sv - error-metric collector for an approximate adder under test
//
// Purpose:
//   Takes operand pairs (A, B) and the approximate sum the adder under test
//   produced (APPROX). It recomputes the exact sum and accumulates error
//   statistics over a programmed batch of num_samples samples.
//
// Pipeline:
//   accept edge    : stage 1 registers exact = A + B and APPROX
//   accept edge +1 : stage 2 registers d = APPROX - exact and ed = |d|
//   accept edge +2 : the accumulators absorb the stage 2 result
//
// Optional feature (macro AXERR_MAXED_EN):
//   Adds the max_ed output, which holds the largest ed seen in the batch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begins a batch (honoured in IDLE/DONE only)
//   num_samples       batch size, captured on an accepted start
//   in_valid/in_ready sample handshake (in_ready high only in RUN)
//   A, B, APPROX      operands and approximate sum under test
//   busy, done        RUN|DRAIN, DONE
//   sample_count      samples accepted in this batch
//   err_count         samples with nonzero error
//   sed               saturating sum of |exact - APPROX|
//   bias              saturating signed sum of (APPROX - exact)
//   sat               sticky: sed or bias clamped
//   max_ed            largest ed in the batch (AXERR_MAXED_EN only)

module axadd_err_monitor #(
    parameter int BIT_WIDTH = 8,
    parameter int CNT_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] A,
    input  logic [BIT_WIDTH-1:0] B,
    input  logic [BIT_WIDTH:0]   APPROX,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [ACC_WIDTH-1:0] sed,
    output logic [ACC_WIDTH-1:0] bias,
`ifdef AXERR_MAXED_EN
    output logic [BIT_WIDTH+1:0] max_ed,
`endif
    output logic                 sat
);

    localparam int SW = BIT_WIDTH + 1;   // sum width
    localparam int DW = BIT_WIDTH + 2;   // signed difference width
    localparam int XW = ACC_WIDTH + 1 - DW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [ACC_WIDTH-1:0] sed_q, sed_d;
    logic [ACC_WIDTH-1:0] bias_q, bias_d;
    logic                 sat_q, sat_d;

    logic          s1_valid_q;
    logic [SW-1:0] s1_exact_q;
    logic [SW-1:0] s1_approx_q;
    logic          s2_valid_q;
    logic [DW-1:0] s2_d_q;
    logic [DW-1:0] s2_ed_q;

    logic          start_ok;
    logic          accept;
    logic          last_accept;
    logic [DW-1:0] diff_c;
    logic [DW-1:0] ed_c;
    logic [ACC_WIDTH:0] sed_sum;
    logic [ACC_WIDTH:0] bias_sum;
    logic               sed_ovf;
    logic               bias_ovf;

    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept      = in_valid && (state_q == ST_RUN);
    assign last_accept = (sample_count_q + CNT_WIDTH'(1)) == target_q;

    // Stage 2 arithmetic: both operands are zero-extended so the subtraction
    // is a true signed difference with one bit of headroom.
    assign diff_c = {1'b0, s1_approx_q} - {1'b0, s1_exact_q};
    assign ed_c   = diff_c[DW-1] ? (~diff_c + DW'(1)) : diff_c;

    // One extra bit on each accumulator sum exposes the overflow.
    assign sed_sum  = {1'b0, sed_q} + {{XW{1'b0}}, s2_ed_q};
    assign bias_sum = {bias_q[ACC_WIDTH-1], bias_q} + {{XW{s2_d_q[DW-1]}}, s2_d_q};
    assign sed_ovf  = sed_sum[ACC_WIDTH];
    assign bias_ovf = bias_sum[ACC_WIDTH] != bias_sum[ACC_WIDTH-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (num_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept && last_accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 1 is empty, so the final sample sits in stage 2 and
                // is absorbed on the same edge that enters DONE.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        target_d       = target_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        sed_d          = sed_q;
        bias_d         = bias_q;
        sat_d          = sat_q;
        if (start_ok) begin
            target_d       = num_samples;
            sample_count_d = '0;
            err_count_d    = '0;
            sed_d          = '0;
            bias_d         = '0;
            sat_d          = 1'b0;
        end else begin
            if (accept) begin
                sample_count_d = sample_count_q + CNT_WIDTH'(1);
            end
            if (s2_valid_q) begin
                if (s2_ed_q != '0) begin
                    err_count_d = err_count_q + CNT_WIDTH'(1);
                end
                if (sed_ovf) begin
                    sed_d = '1;
                    sat_d = 1'b1;
                end else begin
                    sed_d = sed_sum[ACC_WIDTH-1:0];
                end
                if (bias_ovf) begin
                    // The sign of the wide sum tells which rail was crossed.
                    bias_d = bias_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                    sat_d  = 1'b1;
                end else begin
                    bias_d = bias_sum[ACC_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            sed_q          <= '0;
            bias_q         <= '0;
            sat_q          <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_exact_q     <= '0;
            s1_approx_q    <= '0;
            s2_valid_q     <= 1'b0;
            s2_d_q         <= '0;
            s2_ed_q        <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            sed_q          <= sed_d;
            bias_q         <= bias_d;
            sat_q          <= sat_d;
            s1_valid_q     <= accept;
            if (accept) begin
                s1_exact_q  <= {1'b0, A} + {1'b0, B};
                s1_approx_q <= APPROX;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_d_q  <= diff_c;
                s2_ed_q <= ed_c;
            end
        end
    end

`ifdef AXERR_MAXED_EN
    logic [DW-1:0] max_ed_q, max_ed_d;

    always_comb begin
        max_ed_d = max_ed_q;
        if (start_ok) begin
            max_ed_d = '0;
        end else if (s2_valid_q && (s2_ed_q > max_ed_q)) begin
            max_ed_d = s2_ed_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_ed_q <= '0;
        end else begin
            max_ed_q <= max_ed_d;
        end
    end

    assign max_ed = max_ed_q;
`endif

    assign in_ready     = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign sed          = sed_q;
    assign bias         = bias_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_axadd_err_monitor.sv
// tb/tb_axadd_err_monitor.sv - self-checking bench for axadd_err_monitor
module tb_axadd_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [7:0]  A, B;
    logic [8:0]  APPROX;

    logic        in_ready, busy, done, sat;
    logic [15:0] sample_count, err_count;
    logic [31:0] sed, bias;

    logic        s_in_ready, s_busy, s_done, s_sat;
    logic [15:0] s_sample_count, s_err_count;
    logic [9:0]  s_sed, s_bias;
`ifdef AXERR_MAXED_EN
    logic [9:0]  max_ed, s_max_ed;
`endif

    axadd_err_monitor #(.BIT_WIDTH(8), .CNT_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .APPROX(APPROX),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .sed(sed), .bias(bias),
`ifdef AXERR_MAXED_EN
        .max_ed(max_ed),
`endif
        .sat(sat)
    );

    axadd_err_monitor #(.BIT_WIDTH(8), .CNT_WIDTH(16), .ACC_WIDTH(10)) dut_s (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .A(A), .B(B), .APPROX(APPROX),
        .busy(s_busy), .done(s_done), .sample_count(s_sample_count), .err_count(s_err_count),
        .sed(s_sed), .bias(s_bias),
`ifdef AXERR_MAXED_EN
        .max_ed(s_max_ed),
`endif
        .sat(s_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] ap;
        int         exp_sed;
        int         exp_bias;
        int         exp_err;
    } vec_t;

    vec_t tbl[7];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int n);
        num_samples = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
        A = a; B = b; APPROX = ap;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        logic [4:0] pat;
        int         n_acc;
        logic       rdy5;

        tbl[0] = '{8'h1F, 8'h01, 9'h000, 32, -32, 1};
        tbl[1] = '{8'd10, 8'd20, 9'd30, 0, 0, 0};
        tbl[2] = '{8'hFF, 8'hFF, 9'h1FF, 1, 1, 1};
        tbl[3] = '{8'h00, 8'h00, 9'h1FF, 511, 511, 1};
        tbl[4] = '{8'h80, 8'h80, 9'h0F0, 16, -16, 1};
        tbl[5] = '{8'd3, 8'd4, 9'd7, 0, 0, 0};
        tbl[6] = '{8'hFF, 8'hFF, 9'h000, 510, -510, 1};

        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        A = '0; B = '0; APPROX = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sample_count", 32'(sample_count), 32'd0);
        chk("rst_sed_bias", sed | bias | 32'(err_count) | 32'(sat), 32'd0);
        rst = 1'b0;
        tick();

        // Exact samples, back to back
        start_batch(4);
        chk("exact_in_ready", 32'(in_ready), 32'd1);
        send(8'd10, 8'd20, 9'd30);
        send(8'd255, 8'd255, 9'd510);
        send(8'd0, 8'd0, 9'd0);
        send(8'd1, 8'd2, 9'd3);
        chk("exact_count", 32'(sample_count), 32'd4);
        chk("exact_ready_low", 32'(in_ready), 32'd0);
        wait_done();
        chk("exact_err", 32'(err_count), 32'd0);
        chk("exact_sed", sed, 32'd0);
        chk("exact_bias", bias, 32'd0);
        chk("exact_sat", 32'(sat), 32'd0);

        // Truncation-style error with exact latency
        start_batch(1);
        send(8'h1F, 8'h01, 9'h000);
        chk("lat_sed_e0", sed, 32'd0);
        tick();
        chk("lat_sed_e1", sed, 32'd0);
        chk("lat_done_e1", 32'(done), 32'd0);
        tick();
        chk("lat_sed_e2", sed, 32'd32);
        chk("lat_bias_e2", bias, -32'sd32);
        chk("lat_err_e2", 32'(err_count), 32'd1);
        chk("lat_done_e2", 32'(done), 32'd1);
`ifdef AXERR_MAXED_EN
        chk("lat_max_ed", 32'(max_ed), 32'd32);
`endif

        // Table of single-sample batches
        for (int i = 0; i < 7; i++) begin
            start_batch(1);
            send(tbl[i].a, tbl[i].b, tbl[i].ap);
            wait_done();
            chk($sformatf("tbl%0d_sed", i), sed, 32'(tbl[i].exp_sed));
            chk($sformatf("tbl%0d_bias", i), bias, 32'(tbl[i].exp_bias));
            chk($sformatf("tbl%0d_err", i), 32'(err_count), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_cnt", i), 32'(sample_count), 32'd1);
`ifdef AXERR_MAXED_EN
            chk($sformatf("tbl%0d_max_ed", i), 32'(max_ed), 32'(tbl[i].exp_sed));
`endif
        end

        // Back-pressure: in_valid 1,0,1,1,1 with a batch of 3
        start_batch(3);
        pat = 5'b11101;
        n_acc = 0;
        rdy5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            A = 8'(i); B = 8'd1; APPROX = 9'(i + 1);
            in_valid = pat[i];
            if (i == 4) rdy5 = in_ready;
            if (in_valid && in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 32'(n_acc), 32'd3);
        chk("bp_ready_5th", 32'(rdy5), 32'd0);
        chk("bp_count", 32'(sample_count), 32'd3);
        wait_done();
        chk("bp_count_done", 32'(sample_count), 32'd3);
        chk("bp_err", 32'(err_count), 32'd0);

        // Reset mid-batch
        start_batch(5);
        send(8'd0, 8'd0, 9'd5);
        send(8'd0, 8'd0, 9'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_count", 32'(sample_count), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        A = 8'd1; B = 8'd1; APPROX = 9'd0; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("mrst_ignored_count", 32'(sample_count), 32'd0);
        chk("mrst_ignored_stats", sed | bias | 32'(err_count), 32'd0);
        chk("mrst_idle", 32'(busy | done), 32'd0);

        // Zero batch from IDLE, then restart into RUN
        start_batch(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_ready", 32'(in_ready), 32'd0);
        chk("zero_stats", sed | bias | 32'(err_count) | 32'(sample_count), 32'd0);
        start_batch(2);
        chk("zero_restart_busy", 32'(busy), 32'd1);
        chk("zero_restart_ready", 32'(in_ready), 32'd1);
        send(8'd2, 8'd2, 9'd4);
        send(8'd2, 8'd2, 9'd1);
        wait_done();
        chk("zero_restart_count", 32'(sample_count), 32'd2);
        chk("zero_restart_bias", bias, -32'sd3);

        // Saturation on the narrow-accumulator instance
        start_batch(5);
        for (int i = 0; i < 5; i++) send(8'hFF, 8'hFF, 9'h000);
        wait_done();
        chk("sat_s_sed", 32'(s_sed), 32'd1023);
        chk("sat_s_bias", 32'(s_bias), 32'h200);
        chk("sat_s_sat", 32'(s_sat), 32'd1);
        chk("sat_wide_sed", sed, 32'd2550);
        chk("sat_wide_bias", bias, -32'sd2550);
        chk("sat_wide_sat", 32'(sat), 32'd0);
        chk("sat_err", 32'(err_count), 32'd5);
        tick(); tick(); tick();
        chk("sat_hold_sat", 32'(s_sat), 32'd1);
        chk("sat_hold_sed", 32'(s_sed), 32'd1023);
        chk("sat_hold_done", 32'(s_done), 32'd1);
        start_batch(1);
        chk("sat_cleared", 32'(s_sat), 32'd0);
        send(8'd1, 8'd1, 9'd2);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
